// File: rtl/cpu_pkg.sv
// Shared types and constants for the core-to-memory sequencer.
package cpu_pkg;

    // Sequencer steps for one instruction.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        DATA   = 2'd2,
        COMMIT = 2'd3
    } mem_state_t;

    // data_width encodings; 2'b11 is handled as a word access.
    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering between the core and a 32-bit bus.
// Store side: lane enables and lane-replicated write data.
// Load side: picks the addressed lane from the read word and sign/zero extends it.
module mem_lane_align
    import cpu_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  offset,
    input  logic        load_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdat,
    output logic [3:0]  sel,
    output logic [31:0] wdat,
    output logic [31:0] load_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Misaligned halves drop offset[0]; misaligned words drop the whole offset.
    assign rd_byte = rdat[{offset, 3'b000} +: 8];
    assign rd_half = offset[1] ? rdat[31:16] : rdat[15:0];

    // Store lane enables and replicated data.
    always_comb begin
        sel  = 4'b1111;
        wdat = store_data;
        case (width)
            WIDTH_BYTE: begin
                sel  = 4'b0001 << offset;
                wdat = {4{store_data[7:0]}};
            end
            WIDTH_HALF: begin
                sel  = 4'b0011 << {offset[1], 1'b0};
                wdat = {2{store_data[15:0]}};
            end
            WIDTH_WORD: ;
            default: ;
        endcase
    end

    // Load lane extraction and extension.
    always_comb begin
        load_data = rdat;
        case (width)
            WIDTH_BYTE: load_data = load_unsigned ? {24'b0, rd_byte}
                                                  : {{24{rd_byte[7]}}, rd_byte};
            WIDTH_HALF: load_data = load_unsigned ? {16'b0, rd_half}
                                                  : {{16{rd_half[15]}}, rd_half};
            WIDTH_WORD: ;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_request_handler.sv
// mem_request_handler: per-instruction sequencer between the core and the shared memory bus.
// Fetches the word at pc, holds it for one decode cycle, performs any load/store, then
// pulses pc_enable for one cycle. Optional macro MEM_REQUEST_HANDLER_TIMEOUT_EN adds a
// bus-ack watchdog that abandons a stuck request and sets the sticky bus_err flag.
module mem_request_handler
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        pc_enable,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  data_width,
    input  logic        load_unsigned,
    input  logic [31:0] data_adr,
    input  logic [31:0] write_to_mem,
    output logic [31:0] load,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdat,
    input  logic [31:0] bus_rdat,
    input  logic        bus_ack,
    output logic        bus_err
);

    mem_state_t  state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] load_q, load_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  sel_q, sel_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic        pc_en_q, pc_en_d;
    // Access shape captured on entry to DATA, used to extract the load at ack time.
    logic [1:0]  width_q, width_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;

    logic [1:0]  al_width;
    logic [1:0]  al_off;
    logic        al_uns;
    logic [3:0]  al_sel;
    logic [31:0] al_wdat;
    logic [31:0] al_load;

    logic        ack;
    logic        timeout;
    logic [31:0] pc_word;
    logic        unused_pc_lsb;

    // An ack only counts while a request is outstanding.
    assign ack           = bus_ack & req_q;
    assign pc_word       = {pc[31:2], 2'b00};
    assign unused_pc_lsb = ^pc[1:0];

    // Store shape comes straight from the core while deciding; loads use the captured shape.
    assign al_width = (state_q == DECODE) ? data_width       : width_q;
    assign al_off   = (state_q == DECODE) ? data_adr[1:0]    : off_q;
    assign al_uns   = (state_q == DECODE) ? load_unsigned    : uns_q;

    mem_lane_align u_lane_align (
        .width         (al_width),
        .offset        (al_off),
        .load_unsigned (al_uns),
        .store_data    (write_to_mem),
        .rdat          (bus_rdat),
        .sel           (al_sel),
        .wdat          (al_wdat),
        .load_data     (al_load)
    );

`ifdef MEM_REQUEST_HANDLER_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CntW-1:0] wait_q, wait_d;
    logic            err_q, err_d;

    // Count request cycles that have gone without an ack; expire on the last allowed one.
    always_comb begin
        wait_d = wait_q;
        err_d  = err_q | timeout;
        if (!req_q || ack) begin
            wait_d = '0;
        end else begin
            wait_d = wait_q + CntW'(1);
        end
    end

    assign timeout = req_q & ~bus_ack & (wait_q == CntW'(TIMEOUT_CYCLES - 1));
    assign bus_err = err_q;

    // Watchdog counter and sticky error flag.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
    assign bus_err = 1'b0;
`endif

    // Next-state and bus request launch/retire decisions.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        load_d  = load_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        req_d   = req_q;
        we_d    = we_q;
        width_d = width_q;
        off_d   = off_q;
        uns_d   = uns_q;

        unique case (state_q)
            FETCH: begin
                if (!req_q) begin
                    // Only reached straight out of reset.
                    req_d = 1'b1;
                    we_d  = 1'b0;
                    sel_d = 4'b1111;
                end else if (ack || timeout) begin
                    instr_d = ack ? bus_rdat : NOP_INSTR;
                    adr_d   = pc_word;
                    req_d   = 1'b0;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (mem_write || mem_read) begin
                    req_d   = 1'b1;
                    we_d    = mem_write;
                    adr_d   = {data_adr[31:2], 2'b00};
                    sel_d   = al_sel;
                    width_d = data_width;
                    off_d   = data_adr[1:0];
                    uns_d   = load_unsigned;
                    if (mem_write) begin
                        wdat_d = al_wdat;
                    end
                    state_d = DATA;
                end else begin
                    state_d = COMMIT;
                end
            end
            DATA: begin
                if (ack || timeout) begin
                    // A timed-out store is simply dropped.
                    if (!we_q) begin
                        load_d = ack ? al_load : 32'h0;
                    end
                    req_d   = 1'b0;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                // Launch the next fetch on the same edge the core advances pc.
                req_d   = 1'b1;
                we_d    = 1'b0;
                sel_d   = 4'b1111;
                state_d = FETCH;
            end
        endcase

        pc_en_d = (state_d == COMMIT);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge hz100 or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            instr_q <= NOP_INSTR;
            load_q  <= 32'h0;
            adr_q   <= 32'h0;
            wdat_q  <= 32'h0;
            sel_q   <= 4'b0000;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            pc_en_q <= 1'b0;
            width_q <= WIDTH_WORD;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            load_q  <= load_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            req_q   <= req_d;
            we_q    <= we_d;
            pc_en_q <= pc_en_d;
            width_q <= width_d;
            off_q   <= off_d;
            uns_q   <= uns_d;
        end
    end

    assign instruction = instr_q;
    assign load        = load_q;
    assign pc_enable   = pc_en_q;
    assign bus_req     = req_q;
    assign bus_we      = we_q;
    assign bus_sel     = sel_q;
    assign bus_wdat    = wdat_q;
    // pc is a core register that only moves on the commit edge, so it is steady for the
    // whole fetch request; outside a fetch the captured address is presented.
    assign bus_adr     = (state_q == FETCH && req_q) ? pc_word : adr_q;

endmodule
